// File: rtl/priority_decoder_seq.sv
// priority_decoder_seq: regenerates a registered one-hot line from an encoded index,
// holding each line HOLD cycles behind a valid/ready handshake.
module priority_decoder_seq #(
  parameter int N    = 4,
  parameter int W    = 2,
  parameter int HOLD = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_code,
  input  logic         s_any,
  output logic [N-1:0] d_onehot,
  output logic         d_active,
  output logic         d_last,
  output logic         err
);
  localparam int CW = $clog2(HOLD + 1);
  localparam logic [W:0] N_W = N[W:0];
  typedef enum logic {S_IDLE, S_HOLD} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_onehot;
  logic          r_err;
  logic          w_cnt_zero, w_accept, w_in_range, w_load;
  assign w_cnt_zero = r_cnt == '0;
  assign s_ready    = (r_state == S_IDLE) | (r_state == S_HOLD & w_cnt_zero);
  assign w_accept   = s_valid & s_ready;
  assign w_in_range = {1'b0, s_code} < N_W;
  assign w_load     = w_accept & s_any & w_in_range;
  assign d_onehot   = r_onehot;
  assign d_active   = |r_onehot;
  assign d_last     = d_active & w_cnt_zero;
  assign err        = r_err;
  // A reload in the last hold cycle replaces the line directly, so no idle gap appears.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_onehot <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept & s_any & ~w_in_range;
      if (w_accept) begin
        r_onehot <= w_load ? N'(1) << s_code : '0;
        r_state  <= w_load ? S_HOLD : S_IDLE;
        r_cnt    <= w_load ? CW'(HOLD - 1) : '0;
      end else if (r_state == S_HOLD) begin
        r_onehot <= w_cnt_zero ? '0 : r_onehot;
        r_state  <= w_cnt_zero ? S_IDLE : S_HOLD;
        r_cnt    <= w_cnt_zero ? r_cnt : r_cnt - CW'(1);
      end
    end
endmodule

// File: tb/tb_priority_decoder_seq.sv
// tb_priority_decoder_seq: scoreboard bench over three configurations
// (N=4/HOLD=3, N=3/HOLD=3, N=4/HOLD=1).
module tb_priority_decoder_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       v[3], an[3], rdy[3], act[3], lst[3], er[3];
  logic [1:0] cd[3];
  logic [3:0] oh0, oh2;
  logic [2:0] oh1;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int         id;
    logic [3:0] oh;
    logic       rdy, lst, er;
  } exp_t;
  exp_t q[$];

  priority_decoder_seq #(.N(4), .W(2), .HOLD(3)) u_a (
    .clk(clk), .rst_n(rst_n), .s_valid(v[0]), .s_ready(rdy[0]), .s_code(cd[0]), .s_any(an[0]),
    .d_onehot(oh0), .d_active(act[0]), .d_last(lst[0]), .err(er[0]));
  priority_decoder_seq #(.N(3), .W(2), .HOLD(3)) u_b (
    .clk(clk), .rst_n(rst_n), .s_valid(v[1]), .s_ready(rdy[1]), .s_code(cd[1]), .s_any(an[1]),
    .d_onehot(oh1), .d_active(act[1]), .d_last(lst[1]), .err(er[1]));
  priority_decoder_seq #(.N(4), .W(2), .HOLD(1)) u_c (
    .clk(clk), .rst_n(rst_n), .s_valid(v[2]), .s_ready(rdy[2]), .s_code(cd[2]), .s_any(an[2]),
    .d_onehot(oh2), .d_active(act[2]), .d_last(lst[2]), .err(er[2]));

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0;
      an[i] = 1'b0;
      cd[i] = 2'b00;
    end
  endtask

  // expectation describes outputs seen just after the edge that samples these inputs
  task automatic drv(int id, logic vv, logic aa, logic [1:0] cc, logic [3:0] oh, logic r, logic l, logic e);
    @(negedge clk);
    idle_inputs();
    v[id] = vv;
    an[id] = aa;
    cd[id] = cc;
    q.push_back('{id: id, oh: oh, rdy: r, lst: l, er: e});
  endtask

  initial forever begin
    exp_t e;
    logic [3:0] g;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = e.id == 0 ? oh0 : e.id == 1 ? {1'b0, oh1} : oh2;
      chk($sformatf("onehot[%0d]", e.id), g, e.oh);
      chk($sformatf("active[%0d]", e.id), 4'(act[e.id]), 4'(|e.oh));
      chk($sformatf("ready[%0d]", e.id), 4'(rdy[e.id]), 4'(e.rdy));
      chk($sformatf("last[%0d]", e.id), 4'(lst[e.id]), 4'(e.lst));
      chk($sformatf("err[%0d]", e.id), 4'(er[e.id]), 4'(e.er));
    end
  end

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready[%0d]", i), 4'(rdy[i]), 4'd1);
      chk($sformatf("rst_active[%0d]", i), 4'(act[i]), 4'd0);
      chk($sformatf("rst_last[%0d]", i), 4'(lst[i]), 4'd0);
      chk($sformatf("rst_err[%0d]", i), 4'(er[i]), 4'd0);
    end
    chk("rst_oh0", oh0, 4'd0);
    chk("rst_oh1", {1'b0, oh1}, 4'd0);
    chk("rst_oh2", oh2, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // single decode
    drv(0, 1, 1, 2'd2, 4'b0100, 0, 0, 0);
    drv(0, 0, 0, 2'd0, 4'b0100, 0, 0, 0);
    drv(0, 0, 0, 2'd0, 4'b0100, 1, 1, 0);
    drv(0, 0, 0, 2'd0, 4'b0000, 1, 0, 0);
    // back-to-back reload, source holds code 01 while stalled
    drv(0, 1, 1, 2'd3, 4'b1000, 0, 0, 0);
    drv(0, 1, 1, 2'd1, 4'b1000, 0, 0, 0);
    drv(0, 1, 1, 2'd1, 4'b1000, 1, 1, 0);
    drv(0, 1, 1, 2'd1, 4'b0010, 0, 0, 0);
    drv(0, 0, 0, 2'd0, 4'b0010, 0, 0, 0);
    drv(0, 0, 0, 2'd0, 4'b0010, 1, 1, 0);
    drv(0, 0, 0, 2'd0, 4'b0000, 1, 0, 0);
    // no-request accepts: in final hold cycle, then from idle
    drv(0, 1, 1, 2'd0, 4'b0001, 0, 0, 0);
    drv(0, 0, 0, 2'd0, 4'b0001, 0, 0, 0);
    drv(0, 0, 0, 2'd0, 4'b0001, 1, 1, 0);
    drv(0, 1, 0, 2'd2, 4'b0000, 1, 0, 0);
    drv(0, 1, 0, 2'd1, 4'b0000, 1, 0, 0);
    // out of range on N=3
    drv(1, 1, 1, 2'd3, 4'b0000, 1, 0, 1);
    drv(1, 0, 0, 2'd0, 4'b0000, 1, 0, 0);
    drv(1, 1, 1, 2'd1, 4'b0010, 0, 0, 0);
    drv(1, 0, 0, 2'd0, 4'b0010, 0, 0, 0);
    drv(1, 0, 0, 2'd0, 4'b0010, 1, 1, 0);
    drv(1, 0, 0, 2'd0, 4'b0000, 1, 0, 0);
    // HOLD=1 streaming
    drv(2, 1, 1, 2'd0, 4'b0001, 1, 1, 0);
    drv(2, 1, 1, 2'd1, 4'b0010, 1, 1, 0);
    drv(2, 1, 1, 2'd2, 4'b0100, 1, 1, 0);
    drv(2, 1, 1, 2'd3, 4'b1000, 1, 1, 0);
    drv(2, 1, 0, 2'd2, 4'b0000, 1, 0, 0);
    drv(2, 1, 1, 2'd2, 4'b0100, 1, 1, 0);
    drv(2, 0, 0, 2'd0, 4'b0000, 1, 0, 0);
    // asynchronous reset in the middle of a hold window
    drv(0, 1, 1, 2'd2, 4'b0100, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_onehot", oh0, 4'd0);
    chk("midrst_active", 4'(act[0]), 4'd0);
    chk("midrst_ready", 4'(rdy[0]), 4'd1);
    chk("midrst_last", 4'(lst[0]), 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, 0, 0, 2'd0, 4'b0000, 1, 0, 0);
    drv(0, 0, 0, 2'd0, 4'b0000, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", 4'(q.size()), 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
